// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: grid geometry, RGB332 fields, fill FSM states, command structs.
// Latency: none (package only).
// Backpressure: none (package only).
package fb_pkg;

    // Character-cell grid geometry; FB_W*FB_H = 4800 fits in AW bits
    localparam int FB_W = 80;
    localparam int FB_H = 60;
    localparam int AW   = 13;

    // Command coordinate widths
    localparam int XW = 7;
    localparam int YW = 6;

    // RGB332 field positions within a cell byte
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fb_state_t;

    // Rectangle command as captured from the command port
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [7:0]    color;
    } rect_cmd_t;

    // Command after clipping against the grid
    typedef struct packed {
        logic          empty;
        logic [XW-1:0] x_end;
        logic [YW-1:0] y_end;
        logic [AW-1:0] row_base;
    } rect_clip_t;

    // y*FB_W without a multiplier: y*64 + y*16
    function automatic logic [AW-1:0] row_base_of(input logic [YW-1:0] y);
        return AW'({y, 6'b0}) + AW'({y, 4'b0});
    endfunction

    // Pack separate colour components into one RGB332 byte
    function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g,
                                          input logic [1:0] b);
        logic [7:0] px;
        px = '0;
        px[R_MSB:R_LSB] = r;
        px[G_MSB:G_LSB] = g;
        px[B_MSB:B_LSB] = b;
        return px;
    endfunction

endpackage

// File: rtl/fb_rect_fill_clip.sv
// Clips a rectangle command to the grid and derives the first row's base address.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the command fields.
module fb_rect_fill_clip
    import fb_pkg::*;
(
    input  rect_cmd_t  cmd,
    output rect_clip_t clip
);

    logic [XW:0] x_sum;
    logic [YW:0] y_sum;

    // Sums are one bit wider than the operands so x+w and y+h never wrap
    always_comb begin
        clip  = '0;
        x_sum = {1'b0, cmd.x} + {1'b0, cmd.w};
        y_sum = {1'b0, cmd.y} + {1'b0, cmd.h};

        clip.empty = (cmd.x >= XW'(FB_W)) || (cmd.y >= YW'(FB_H)) ||
                     (cmd.w == '0) || (cmd.h == '0);

        // Non-empty commands have x<FB_W and w>=1, so the sum is at least 1
        if (x_sum > (XW+1)'(FB_W))
            clip.x_end = XW'(FB_W - 1);
        else
            clip.x_end = x_sum[XW-1:0] - XW'(1);

        if (y_sum > (YW+1)'(FB_H))
            clip.y_end = YW'(FB_H - 1);
        else
            clip.y_end = y_sum[YW-1:0] - YW'(1);

        clip.row_base = row_base_of(cmd.y);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: one command in, one clipped row-major framebuffer write per grant.
// Latency: first write 1 cycle after accept; done 1 cycle after the last granted write.
// Backpressure: cmd_ready low while busy; write address/data hold until fb_gnt.
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [7:0]    cmd_color,
    output logic          fb_we,
    input  logic          fb_gnt,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic          busy,
    output logic          done
);

    fb_state_t     state;
    rect_cmd_t     cmd;
    rect_clip_t    clip;

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] x_start;
    logic [XW-1:0] x_end;
    logic [YW-1:0] y_end;
    logic [AW-1:0] row_base;
    logic          accept;

    assign cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
    assign accept = cmd_valid && cmd_ready;

    fb_rect_fill_clip u_clip (
        .cmd  (cmd),
        .clip (clip)
    );

    // Fill sequencer: all outputs registered; address advances by increment, never by multiply
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            col       <= '0;
            row       <= '0;
            x_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            row_base  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (clip.empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FILL;
                            fb_we    <= 1'b1;
                            fb_data  <= cmd_color;
                            col      <= cmd_x;
                            row      <= cmd_y;
                            x_start  <= cmd_x;
                            x_end    <= clip.x_end;
                            y_end    <= clip.y_end;
                            row_base <= clip.row_base;
                            fb_addr  <= clip.row_base + AW'(cmd_x);
                        end
                    end
                end
                FILL: begin
                    if (fb_gnt) begin
                        if (col < x_end) begin
                            col     <= col + 1'b1;
                            fb_addr <= fb_addr + 1'b1;
                        end else if (row < y_end) begin
                            col      <= x_start;
                            row      <= row + 1'b1;
                            row_base <= row_base + AW'(FB_W);
                            fb_addr  <= row_base + AW'(FB_W) + AW'(x_start);
                        end else begin
                            fb_we <= 1'b0;
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    fb_we     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: scoreboard of expected writes per command.
// Latency: checks first-write, done and ready timing cycle by cycle.
// Backpressure: drives tied, alternating and random grant patterns.
module tb_fb_rect_fill;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [6:0]  cmd_w;
    logic [5:0]  cmd_h;
    logic [7:0]  cmd_color;
    logic        fb_we;
    logic        fb_gnt;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] exp_q[$];

    fb_rect_fill dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_we     (fb_we),
        .fb_gnt    (fb_gnt),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // gmode: 0 = grant tied high, 1 = low on odd cycles, 2 = random
    // abort_after: if nonzero, pulse reset once that many writes were granted
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                           input int gmode, input int abort_after);
        int          exp_n;
        int          cyc;
        int          grants;
        int          last_g;
        int          budget;
        bit          seen_done;
        bit          aborted;
        bit          holding;
        logic [12:0] held;
        logic [20:0] e;

        exp_n = 0;
        if (!(x >= 80 || y >= 60 || w == 0 || h == 0)) begin
            for (int yy = y; yy < y + h && yy < 60; yy++) begin
                for (int xx = x; xx < x + w && xx < 80; xx++) begin
                    exp_q.push_back({13'(yy * 80 + xx), 8'(c)});
                    exp_n++;
                end
            end
        end

        @(negedge CLK);
        check("ready_idle", {31'b0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_x     = 7'(x);
        cmd_y     = 6'(y);
        cmd_w     = 7'(w);
        cmd_h     = 6'(h);
        cmd_color = 8'(c);
        fb_gnt    = 1'($urandom_range(0, 1));

        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_x     = 7'($urandom);
        cmd_y     = 6'($urandom);
        cmd_w     = 7'($urandom);
        cmd_h     = 6'($urandom);
        cmd_color = 8'($urandom);

        cyc       = 1;
        grants    = 0;
        last_g    = 0;
        seen_done = 0;
        aborted   = 0;
        holding   = 0;
        held      = '0;
        budget    = exp_n * 8 + 20;

        if (exp_n > 0) check("first_we", {31'b0, fb_we}, 1);
        else           check("empty_no_we", {31'b0, fb_we}, 0);

        while (cyc <= budget && !seen_done && !aborted) begin
            if (done) begin
                seen_done = 1;
                check("q_drained", exp_q.size(), 0);
                check("done_latency", cyc, (exp_n > 0) ? last_g + 1 : 1);
                check("write_count", grants, exp_n);
                check("busy_in_done", {31'b0, busy}, 1);
                check("ready_in_done", {31'b0, cmd_ready}, 0);
                check("we_in_done", {31'b0, fb_we}, 0);
            end else begin
                case (gmode)
                    0:       fb_gnt = 1'b1;
                    1:       fb_gnt = (cyc % 2 == 0);
                    default: fb_gnt = 1'($urandom_range(0, 1));
                endcase
                if (holding) check("addr_hold", {19'b0, fb_addr}, {19'b0, held});
                if (!fb_we) check("we_gap", {31'b0, fb_we}, 1);
                if (fb_we && fb_gnt) begin
                    if (exp_q.size() == 0) begin
                        check("extra_write", {19'b0, fb_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("addr", {19'b0, fb_addr}, {19'b0, e[20:8]});
                        check("data", {24'b0, fb_data}, {24'b0, e[7:0]});
                    end
                    grants++;
                    last_g  = cyc;
                    holding = 0;
                    if (abort_after > 0 && grants == abort_after) begin
                        aborted = 1;
                        RST     = 1'b1;
                    end
                end else begin
                    holding = fb_we;
                    held    = fb_addr;
                end
                @(negedge CLK);
                cyc++;
            end
        end

        if (aborted) begin
            check("rst_we", {31'b0, fb_we}, 0);
            check("rst_busy", {31'b0, busy}, 0);
            check("rst_ready", {31'b0, cmd_ready}, 1);
            check("rst_done", {31'b0, done}, 0);
            RST = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                check("no_done_after_rst", {31'b0, done}, 0);
                check("no_we_after_rst", {31'b0, fb_we}, 0);
            end
        end else if (!seen_done) begin
            check("timeout_waiting_done", 0, 1);
            exp_q.delete();
        end else begin
            @(negedge CLK);
            check("done_one_cycle", {31'b0, done}, 0);
            check("ready_back", {31'b0, cmd_ready}, 1);
            check("busy_clear", {31'b0, busy}, 0);
        end
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        fb_gnt    = 1'b1;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_ready", {31'b0, cmd_ready}, 1);
        check("reset_we", {31'b0, fb_we}, 0);
        check("reset_addr", {19'b0, fb_addr}, 0);
        check("reset_data", {24'b0, fb_data}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        RST = 1'b0;

        // Basic 2x2 fill: addresses 83,84,163,164
        run_cmd(3, 1, 2, 2, 8'hE0, 0, 0);
        // Bottom-right clip: 4718,4719,4798,4799
        run_cmd(78, 58, 5, 5, 8'h1C, 0, 0);
        // Empty commands: zero width, x off-grid, y off-grid
        run_cmd(10, 10, 0, 4, 8'hFF, 0, 0);
        run_cmd(80, 10, 3, 4, 8'hFF, 0, 0);
        run_cmd(5, 60, 3, 4, 8'hAA, 0, 0);
        // Grant stalled every other cycle
        run_cmd(0, 0, 3, 1, 8'h03, 1, 0);
        // Bottom-row clip with random grants
        run_cmd(5, 59, 3, 3, 8'h55, 2, 0);
        // Right-edge clip spanning rows, random grants
        run_cmd(76, 10, 20, 3, 8'h96, 2, 0);
        // Full screen
        run_cmd(0, 0, 80, 60, 8'h00, 0, 0);
        // Reset after 5 writes, then a normal command
        run_cmd(0, 0, 10, 2, 8'h77, 0, 5);
        run_cmd(3, 1, 2, 2, 8'hE0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
